cond_unit: RTL and testbench

Conditional-execution unit for the pipelined ARM core; it sits downstream of the ALU decoder and consumes its FlagW and NoWrite outputs. It registers decode-stage control into an execute-stage register with stall and flush, holds the architectural NZCV flags, and evaluates the instruction condition field against them. It gates register-write, memory-write and PC-write so that only condition-passing instructions commit.

---
 rtl/cond_pkg.sv | 52 +++++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 84 ++++++++
 tb/tb_cond_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for ARM conditional execution.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cond_pkg;

    // ARM condition field encodings (Instr[31:28])
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Bit positions of the flags inside a {N,Z,C,V} vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Execute-stage control register contents
    typedef struct packed {
        cond_t      cond;
        logic [1:0] flag_w;
        logic       no_write;
        logic       reg_w;
        logic       mem_w;
        logic       pcs;
    } ereg_t;

    // Bubble: always-execute with no side effects, so it commits nothing
    localparam ereg_t E_BUBBLE = '{
        cond:     COND_AL,
        flag_w:   2'b00,
        no_write: 1'b0,
        reg_w:    1'b0,
        mem_w:    1'b0,
        pcs:      1'b0
    };

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against an NZCV flag vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_f, z_f, c_f, v_f;
    logic ge_f;

    assign n_f  = flags[FLAG_N];
    assign z_f  = flags[FLAG_Z];
    assign c_f  = flags[FLAG_C];
    assign v_f  = flags[FLAG_V];
    assign ge_f = (n_f == v_f);

    // Condition decode; code 1111 never passes so the output is always defined
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = ge_f;
            COND_LT: cond_ex = ~ge_f;
            COND_GT: cond_ex = ~z_f & ge_f;
            COND_LE: cond_ex = z_f | ~ge_f;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional unit: E register, NZCV flags, gated commit strobes.
// Latency: decode control reaches the E register in 1 cycle; strobes are combinational from it.
// Backpressure: stall holds the E register and suppresses strobes/flag writes; flush inserts a bubble.
module cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] CondD,
    input  logic [1:0] FlagWD,
    input  logic       NoWriteD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       PCSD,
    input  logic [3:0] ALUFlags,
    output logic       CondExE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       PCSrcE,
    output logic [3:0] FlagsE
);

    ereg_t      ereg_q, ereg_d;
    logic [3:0] flags_q, flags_d;
    logic       commit;

    cond_check u_cond_check (
        .cond    (ereg_q.cond),
        .flags   (flags_q),
        .cond_ex (CondExE)
    );

    // An instruction commits only on a passing, non-stalled cycle
    assign commit = CondExE & ~stall;

    assign RegWriteE = ereg_q.reg_w & ~ereg_q.no_write & commit;
    assign MemWriteE = ereg_q.mem_w & commit;
    assign PCSrcE    = ereg_q.pcs & commit;
    assign FlagsE    = flags_q;

    // E register next state: flush beats stall, stall holds, else load decode
    always_comb begin
        ereg_d = ereg_q;
        if (flush) begin
            ereg_d = E_BUBBLE;
        end else if (!stall) begin
            ereg_d.cond     = cond_t'(CondD);
            ereg_d.flag_w   = FlagWD;
            ereg_d.no_write = NoWriteD;
            ereg_d.reg_w    = RegWD;
            ereg_d.mem_w    = MemWD;
            ereg_d.pcs      = PCSD;
        end
    end

    // Flag next state: N,Z and C,V groups written independently on commit
    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (ereg_q.flag_w[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (ereg_q.flag_w[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            ereg_q  <= E_BUBBLE;
            flags_q <= 4'b0000;
        end else begin
            ereg_q  <= ereg_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with hand-computed expectations.
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: stall/flush driven directly by the step sequence.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset, stall, flush;
    logic [3:0] CondD;
    logic [1:0] FlagWD;
    logic       NoWriteD, RegWD, MemWD, PCSD;
    logic [3:0] ALUFlags;
    logic       CondExE, RegWriteE, MemWriteE, PCSrcE;
    logic [3:0] FlagsE;

    int vectors = 0;
    int miscompares = 0;

    cond_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .CondD     (CondD),
        .FlagWD    (FlagWD),
        .NoWriteD  (NoWriteD),
        .RegWD     (RegWD),
        .MemWD     (MemWD),
        .PCSD      (PCSD),
        .ALUFlags  (ALUFlags),
        .CondExE   (CondExE),
        .RegWriteE (RegWriteE),
        .MemWriteE (MemWriteE),
        .PCSrcE    (PCSrcE),
        .FlagsE    (FlagsE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decode-stage inputs for the next instruction
    task automatic drv(input logic [3:0] c, input logic [1:0] fw, input logic nw,
                       input logic rw, input logic mw, input logic ps);
        CondD    = c;
        FlagWD   = fw;
        NoWriteD = nw;
        RegWD    = rw;
        MemWD    = mw;
        PCSD     = ps;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; ALUFlags = 4'b0000;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_flags", FlagsE, 4'b0000);
        chk("rst_condex", {3'b0, CondExE}, 4'b0001);
        chk("rst_regw", {3'b0, RegWriteE}, 4'b0000);
        chk("rst_memw", {3'b0, MemWriteE}, 4'b0000);
        chk("rst_pcsrc", {3'b0, PCSrcE}, 4'b0000);
        reset = 1'b0;

        // SUBS-style AL with FlagW=11 sets Z
        drv(4'b1110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b0100;
        drv(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);   // EQ, RegW
        #1;
        chk("subs_condex", {3'b0, CondExE}, 4'b0001);
        tick();
        chk("subs_flags", FlagsE, 4'b0100);
        chk("eq_condex", {3'b0, CondExE}, 4'b0001);
        chk("eq_regw", {3'b0, RegWriteE}, 4'b0001);
        drv(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);   // NE, RegW
        tick();
        chk("ne_condex", {3'b0, CondExE}, 4'b0000);
        chk("ne_regw", {3'b0, RegWriteE}, 4'b0000);

        // CMP: flags written, register write suppressed
        drv(4'b1110, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        ALUFlags = 4'b1001;
        drv(4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);   // GE
        #1;
        chk("cmp_regw", {3'b0, RegWriteE}, 4'b0000);
        tick();
        chk("cmp_flags", FlagsE, 4'b1001);
        chk("ge_condex", {3'b0, CondExE}, 4'b0001);
        drv(4'b1011, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);   // LT
        tick();
        chk("lt_condex", {3'b0, CondExE}, 4'b0000);

        // Failing EQ with FlagW=11 and MemW: no flag write, no store
        drv(4'b0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        ALUFlags = 4'b1111;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fail_memw", {3'b0, MemWriteE}, 4'b0000);
        tick();
        chk("fail_flags", FlagsE, 4'b1001);

        // Branch held by two stall cycles commits exactly once
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        stall = 1'b1;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("br_stall1", {3'b0, PCSrcE}, 4'b0000);
        tick();
        chk("br_stall2", {3'b0, PCSrcE}, 4'b0000);
        stall = 1'b0;
        #1;
        chk("br_commit", {3'b0, PCSrcE}, 4'b0001);
        tick();
        chk("br_once", {3'b0, PCSrcE}, 4'b0000);

        // Stalled flag-setting instruction writes flags only once released
        drv(4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        ALUFlags = 4'b0110;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall_flags", FlagsE, 4'b1001);
        stall = 1'b0;
        tick();
        chk("unstall_flags", FlagsE, 4'b0110);

        // Stall and flush together with a store in E: bubble, no store
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("sf_memw_now", {3'b0, MemWriteE}, 4'b0000);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sf_memw_next", {3'b0, MemWriteE}, 4'b0000);
        chk("sf_bubble_condex", {3'b0, CondExE}, 4'b0001);

        // Reset in flight: the register write never commits
        drv(4'b1110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drv(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_regw", {3'b0, RegWriteE}, 4'b0000);
        chk("rst_mid_flags", FlagsE, 4'b0000);
        chk("rst_mid_condex", {3'b0, CondExE}, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
